fir_stage_scheduler: RTL

- Sequencer and two-channel time-division arbiter for one shared 2-way-interleaved FIR filter stage, e.g. fir_filter_stage_kpow2 on the pitch and volume paths.
- Generates the stage's PHASE signal and presents each channel's held sample in that channel's slot.
- Demultiplexes the stage output back to per-channel decimated outputs.
- Runs a flush sequence that clears filter state before live data is admitted.

---
 rtl/fir_stage_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fir_stage_scheduler.sv
// fir_stage_scheduler: flushes, time-slices and demuxes one shared 2-way interleaved FIR stage; results land STAGE_LATENCY+1 cycles after their slot.
// Each channel accepts at most once per 2 cycles (READY low while a sample waits for its slot); FIR_STAGE_SCHED_OVERRUN_CNT_EN adds stall counters.
module fir_stage_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int STAGE_LATENCY = 4,
  parameter int DECIM         = 1,
  parameter int FLUSH_CYCLES  = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] CH0_IN_VALUE,
  input  logic                  CH0_IN_VALID,
  output logic                  CH0_IN_READY,
  input  logic [DATA_WIDTH-1:0] CH1_IN_VALUE,
  input  logic                  CH1_IN_VALID,
  output logic                  CH1_IN_READY,
  output logic                  FLT_PHASE,
  output logic [DATA_WIDTH-1:0] FLT_IN_VALUE,
  input  logic [DATA_WIDTH-1:0] FLT_OUT_VALUE,
  output logic [DATA_WIDTH-1:0] CH0_OUT_VALUE,
  output logic                  CH0_OUT_VALID,
  output logic [DATA_WIDTH-1:0] CH1_OUT_VALUE,
  output logic                  CH1_OUT_VALID,
`ifdef FIR_STAGE_SCHED_OVERRUN_CNT_EN
  output logic [15:0]           CH0_STALL_CNT,
  output logic [15:0]           CH1_STALL_CNT,
`endif
  output logic                  RUNNING
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

  logic [1:0]                    state_q, state_d;
  logic                          phase_q, phase_d;
  logic [DATA_WIDTH-1:0]         flt_in_q, flt_in_d;
  logic [FCW-1:0]                flush_cnt_q, flush_cnt_d;
  logic [1:0][DATA_WIDTH-1:0]    hold_q, hold_d;
  logic [1:0][DATA_WIDTH-1:0]    out_val_q, out_val_d;
  logic [1:0]                    pend_q, pend_d;
  logic [1:0]                    out_vld_q, out_vld_d;
  logic [1:0][7:0]               dec_q, dec_d;
  logic [STAGE_LATENCY-1:0][1:0] tag_q, tag_d;

  logic [1:0]                    in_vld, in_rdy;
  logic [1:0][DATA_WIDTH-1:0]    in_val;
  logic [1:0]                    tag_out;
  logic                          out_ch;

  assign in_vld  = {CH1_IN_VALID, CH0_IN_VALID};
  assign in_val  = {CH1_IN_VALUE, CH0_IN_VALUE};
  assign in_rdy  = {2{state_q == ST_RUN}} & ~pend_q;
  // Tag = {slot issued in RUN, slot channel}, aligned with FLT_OUT_VALUE on exit.
  assign tag_out = tag_q[STAGE_LATENCY-1];
  assign out_ch  = tag_out[0];

  always_comb begin
    state_d     = state_q;
    phase_d     = ~phase_q;
    flush_cnt_d = flush_cnt_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    dec_d       = dec_q;
    out_val_d   = out_val_q;
    out_vld_d   = '0;
    tag_d       = '0;

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          dec_d       = '0;
          hold_d      = '0;
          pend_d      = '0;
        end
      end
      ST_FLUSH: begin
        if (!ENABLE) state_d = ST_IDLE;
        else if (flush_cnt_q == FLUSH_LAST) state_d = ST_RUN;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (!ENABLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The registered hold (not a same-edge accept) is what goes out in the new slot.
    flt_in_d = (state_d == ST_RUN) ? hold_q[phase_d] : '0;
    for (int n = 0; n < 2; n++) begin
      if (state_d == ST_RUN && phase_d == 1'(n)) pend_d[n] = 1'b0;
      if (in_vld[n] && in_rdy[n]) begin
        hold_d[n] = in_val[n];
        pend_d[n] = 1'b1;
      end
    end

    tag_d[0] = {state_q == ST_RUN, phase_q};
    for (int i = 1; i < STAGE_LATENCY; i++) tag_d[i] = tag_q[i-1];

    if (state_d == ST_IDLE) begin
      tag_d = '0;
    end else if (tag_out[1]) begin
      if (dec_q[out_ch] == DEC_LAST) begin
        dec_d[out_ch]     = '0;
        out_val_d[out_ch] = FLT_OUT_VALUE;
        out_vld_d[out_ch] = 1'b1;
      end else begin
        dec_d[out_ch] = dec_q[out_ch] + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      flt_in_q    <= '0;
      flush_cnt_q <= '0;
      hold_q      <= '0;
      pend_q      <= '0;
      dec_q       <= '0;
      out_val_q   <= '0;
      out_vld_q   <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      flt_in_q    <= flt_in_d;
      flush_cnt_q <= flush_cnt_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      dec_q       <= dec_d;
      out_val_q   <= out_val_d;
      out_vld_q   <= out_vld_d;
      tag_q       <= tag_d;
    end
  end

`ifdef FIR_STAGE_SCHED_OVERRUN_CNT_EN
  logic [1:0][15:0] stall_q, stall_d;

  // Saturating and deliberately kept across IDLE so overruns survive a restart.
  always_comb begin
    stall_d = stall_q;
    for (int n = 0; n < 2; n++) begin
      if (state_q == ST_RUN && in_vld[n] && !in_rdy[n] && stall_q[n] != 16'hFFFF)
        stall_d[n] = stall_q[n] + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign CH0_STALL_CNT = stall_q[0];
  assign CH1_STALL_CNT = stall_q[1];
`endif

  assign CH0_IN_READY  = in_rdy[0];
  assign CH1_IN_READY  = in_rdy[1];
  assign FLT_PHASE     = phase_q;
  assign FLT_IN_VALUE  = flt_in_q;
  assign CH0_OUT_VALUE = out_val_q[0];
  assign CH0_OUT_VALID = out_vld_q[0];
  assign CH1_OUT_VALUE = out_val_q[1];
  assign CH1_OUT_VALID = out_vld_q[1];
  assign RUNNING       = (state_q == ST_RUN);

endmodule
